dev_hex_keypad: RTL and testbench
=================================

Name: dev_hex_keypad

Overview:
- Input-side counterpart of the multiplexed hex display device: scans a 4x4 hex keypad by driving one column low at a time and sampling the four rows.
- Debounces each scan result and emits one event per key press.
- Shifts the pressed hex digit into an 8-bit value whose format matches the display's hex_val input, so the keypad can feed the display directly.

Parameters:
- SCAN_DIV, 4096, clk cycles each column is driven (dwell); must be >= 4 (~341 us at 12 MHz).
- DEBOUNCE_SCANS, 16, consecutive identical full frames required before a state is accepted; must be >= 2.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  device enable; low halts scanning.
- row_n  in  4  keypad rows, active-low, pulled up externally, asynchronous to clk.
- col_n  out  4  keypad column drive, active-low, at most one bit low at a time.
- hex_val  out  8  two most recent digits; the newest digit is in [3:0].
- key_code  out  4  hex code of the last accepted press.
- key_valid  out  1  one-cycle pulse on each accepted press.
- key_down  out  1  high while the accepted key is held.

Behaviour:
- Reset (async, rst_n low): col_n=4'hF, hex_val=0, key_code=0, key_valid=0, key_down=0. The scan counter, column index, candidate and debounce count all clear.
- Synchronisation: row_n passes through a 2-flop synchroniser before any use.
- Scan, column drive: column index c runs 0..3. col_n = ~(1<<c). Dwell counter runs 0..SCAN_DIV-1. At dwell end, c advances and wraps 3->0.
- Scan, sampling: synced rows are sampled on the last dwell cycle only, which allows settle time plus synchroniser latency.
- Frame: one frame is 4 dwells, 4*SCAN_DIV cycles. The frame result is:
  - NONE: no row is low in any column.
  - KEY(code): exactly one (row,col) hit across the frame.
  - MULTI: two or more hits.
- Keymap (row r, col c), rows top to bottom:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce, candidate update: at each frame end, if result == candidate then cnt = min(cnt+1, DEBOUNCE_SCANS); otherwise candidate = result and cnt = 1.
- Debounce, acceptance: the candidate is stable in any frame-end cycle where the updated cnt == DEBOUNCE_SCANS.
- Reported-state FSM, states IDLE and HELD:
  - IDLE, stable KEY(k): go to HELD. In the next cycle: key_valid=1 for exactly one cycle, key_code=k, hex_val={hex_val[3:0],k}, key_down=1.
  - HELD, stable NONE: go to IDLE, key_down=0, no pulse.
  - HELD, stable KEY(other): no event; a release is required before the next press.
  - Stable MULTI in either state: hold the current state, no event.
- Saturation: once cnt saturates, a stable state already acted on generates no repeat events (no auto-repeat).
- Latency: press-to-pulse is at least DEBOUNCE_SCANS frames after first contact and at most DEBOUNCE_SCANS+1 frames.
- en low, synchronous effect:
  - col_n=4'hF; scan, candidate and cnt clear; FSM goes to IDLE; key_down=0; key_valid=0.
  - hex_val and key_code hold their values.
  - Scanning restarts at column 0 on the first cycle en is high.
- en dropping mid-frame: the partial frame is discarded.
- Reset mid-frame: all state clears immediately and asynchronously.
- hex_val wraps naturally: the oldest digit is shifted out.

Decomposition:
- Package dev_keypad_pkg holds:
  - enum frame_res_t {FR_NONE, FR_KEY, FR_MULTI};
  - the 16-entry keymap constant or a function keymap(row, col) -> [3:0];
  - the reported-state enum {KP_IDLE, KP_HELD}.
- Sub-module dev_keypad_debounce:
  - inputs: frame_res_t, code, frame_end strobe, clear;
  - output: stable strobe with the stable result/code.
- The scanner and FSM stay in dev_hex_keypad.

Test Plan (bench uses SCAN_DIV=8, DEBOUNCE_SCANS=4, so a frame is 32 cycles):
- Reset, then en=1 with no keys: col_n cycles E,D,B,7 with 8 cycles each; key_valid never asserts; hex_val=00.
- Key '5' (r1,c1) held clean for 10 frames: exactly one key_valid pulse within frames 4-5; key_code=5; hex_val=05; key_down=1 until release, then key_down=0 within 5 frames.
- Press 'A', release, press 'F': two pulses; hex_val=AF; key_code=F.
- Key '7' bouncing (toggle every 20 cycles for 3 frames), then solid: exactly one pulse, issued only after 4 solid frames.
- '1' and '2' held together: no pulse; release '2' keeping '1': pulse with code 1.
- '3' held, then en=0 for 50 cycles: col_n=F, key_down=0, hex_val held. Raise en with '3' still held: a new pulse; hex_val shifts in 3 again. Assert rst_n=0 mid-frame: all outputs reset asynchronously.

Source files
------------

// File: rtl/dev_keypad_pkg.sv
// Shared types and keymap for the hex keypad scanner.
// Frame results, reported-key states and row/column decode.
package dev_keypad_pkg;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_KEY   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_t;

    typedef enum logic {
        KP_IDLE = 1'b0,
        KP_HELD = 1'b1
    } kp_state_t;

    function automatic logic [3:0] keymap(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] k;
        k = 4'h0;
        case ({row, col})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'h0;
            4'hD: k = 4'hF;
            4'hE: k = 4'hE;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/dev_keypad_debounce.sv
// Frame-level debouncer: a result must repeat for DEBOUNCE_SCANS
// consecutive frames before it is reported as stable.
module dev_keypad_debounce
    import dev_keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       frame_end,
    input  frame_res_t res,
    input  logic [3:0] code,
    output logic       stable,
    output frame_res_t stable_res,
    output logic [3:0] stable_code
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

    frame_res_t    cand_res;
    logic [3:0]    cand_code;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          same;

    always_comb begin
        same = (res == cand_res) &&
               ((res != FR_KEY) || (code == cand_code));
        if (!same)
            cnt_nxt = CW'(1);
        else if (cnt == CMAX)
            cnt_nxt = CMAX;
        else
            cnt_nxt = cnt + 1'b1;
        stable      = frame_end && (cnt_nxt == CMAX);
        stable_res  = res;
        stable_code = code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_res  <= FR_NONE;
            cand_code <= 4'h0;
            cnt       <= '0;
        end else if (clear) begin
            cand_res  <= FR_NONE;
            cand_code <= 4'h0;
            cnt       <= '0;
        end else if (frame_end) begin
            cand_res  <= res;
            cand_code <= code;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: rtl/dev_hex_keypad.sv
// 4x4 hex keypad scanner with debounce and press reporting.
// Shifts each accepted digit into a display-compatible hex_val.
module dev_hex_keypad
    import dev_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] hex_val,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic          scan_on;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [1:0]    hits;
    logic [3:0]    hit_code;

    logic [1:0]    smp_hits;
    logic [3:0]    smp_code;
    logic [2:0]    sum;
    logic [1:0]    tot;
    logic [3:0]    code_sel;
    logic          last;
    logic          frame_end;
    frame_res_t    res;
    logic [3:0]    res_code;

    logic          stable;
    frame_res_t    stable_res;
    logic [3:0]    stable_code;
    kp_state_t     state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    assign col_n = scan_on ? ~(4'b0001 << col) : 4'hF;

    // Hit count saturates at 2: that is all MULTI detection needs.
    always_comb begin
        smp_hits = 2'd0;
        smp_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                smp_code = keymap(2'(r), col);
                if (smp_hits != 2'd2)
                    smp_hits = smp_hits + 2'd1;
            end
        end
        sum      = {1'b0, hits} + {1'b0, smp_hits};
        tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_sel = (smp_hits != 2'd0) ? smp_code : hit_code;
        last      = en && scan_on && (dwell == DLAST);
        frame_end = last && (col == 2'd3);
        res      = FR_MULTI;
        res_code = 4'h0;
        unique case (1'b1)
            (tot == 2'd0): res = FR_NONE;
            (tot == 2'd1): begin
                res      = FR_KEY;
                res_code = code_sel;
            end
            default:       res = FR_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_on  <= 1'b0;
            dwell    <= '0;
            col      <= 2'd0;
            hits     <= 2'd0;
            hit_code <= 4'h0;
        end else if (!en) begin
            scan_on  <= 1'b0;
            dwell    <= '0;
            col      <= 2'd0;
            hits     <= 2'd0;
            hit_code <= 4'h0;
        end else begin
            scan_on <= 1'b1;
            if (scan_on) begin
                if (last) begin
                    dwell <= '0;
                    col   <= col + 2'd1;
                    if (col == 2'd3) begin
                        hits     <= 2'd0;
                        hit_code <= 4'h0;
                    end else begin
                        hits     <= tot;
                        hit_code <= code_sel;
                    end
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end
        end
    end

    dev_keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!en),
        .frame_end  (frame_end),
        .res        (res),
        .code       (res_code),
        .stable     (stable),
        .stable_res (stable_res),
        .stable_code(stable_code)
    );

    // A held key must be released before another press is reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= KP_IDLE;
            hex_val   <= 8'h00;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (!en) begin
                state    <= KP_IDLE;
                key_down <= 1'b0;
            end else if (stable) begin
                unique case (1'b1)
                    (state == KP_IDLE && stable_res == FR_KEY): begin
                        state     <= KP_HELD;
                        key_valid <= 1'b1;
                        key_code  <= stable_code;
                        hex_val   <= {hex_val[3:0], stable_code};
                        key_down  <= 1'b1;
                    end
                    (state == KP_HELD && stable_res == FR_NONE): begin
                        state    <= KP_IDLE;
                        key_down <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dev_hex_keypad.sv
// Scoreboard bench for dev_hex_keypad with a behavioural keypad
// model; SCAN_DIV=8, DEBOUNCE_SCANS=4 gives 32-cycle frames.
module tb_dev_hex_keypad;

    localparam int SD = 8;
    localparam int DB = 4;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [7:0] hex_val;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] keys = 16'h0;
    logic [7:0]  exp_hex = 8'h00;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    int pass_cnt = 0;
    int total = 0;
    int pulses = 0;
    int last_pulse = 0;
    int cyc = 0;

    dev_hex_keypad #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .row_n    (row_n),
        .col_n    (col_n),
        .hex_val  (hex_val),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Key (r,c) is keys[r*4+c]; a pressed key shorts its row to its column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c])
                    row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            obs_q.push_back({hex_val, key_code});
            pulses++;
            last_pulse = cyc;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1, "watchdog");
    end

    task automatic expect_press(input logic [3:0] k);
        exp_hex = {exp_hex[3:0], k};
        exp_q.push_back({exp_hex, k});
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FR) @(negedge clk);
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        while (col_n !== 4'h7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (col_n !== 4'hE && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL frame_sync: col_n=%h never cycled", col_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        keys  = 16'h0;
        repeat (3) @(negedge clk);
        total++;
        if (col_n !== 4'hF)
            $display("FAIL rst_col: got %h want F", col_n);
        else pass_cnt++;
        total++;
        if (hex_val !== 8'h00)
            $display("FAIL rst_hex: got %h want 00", hex_val);
        else pass_cnt++;
        total++;
        if (key_code !== 4'h0)
            $display("FAIL rst_code: got %h want 0", key_code);
        else pass_cnt++;
        total++;
        if (key_valid !== 1'b0 || key_down !== 1'b0)
            $display("FAIL rst_flags: got v=%b d=%b want 0 0",
                     key_valid, key_down);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scan();
        logic [3:0] exp_col[4];
        int n;
        int bad;
        exp_col = '{4'hE, 4'hD, 4'hB, 4'h7};
        en = 1'b1;
        n = 0;
        @(negedge clk);
        while (col_n === 4'hF && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (col_n !== 4'hE)
            $display("FAIL scan_start: got %h want E", col_n);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bad = 0;
            repeat (SD) begin
                if (col_n !== exp_col[i]) bad++;
                @(negedge clk);
            end
            total++;
            if (bad != 0)
                $display("FAIL scan_col%0d: %0d bad cycles want %h",
                         i, bad, exp_col[i]);
            else pass_cnt++;
        end
        wait_frames(6);
        total++;
        if (pulses != 0 || hex_val !== 8'h00)
            $display("FAIL scan_idle: pulses=%0d hex=%h want 0 00",
                     pulses, hex_val);
        else pass_cnt++;
    endtask

    task automatic test_key5();
        int p0;
        int t0;
        int n;
        logic [11:0] got;
        logic [11:0] want;
        wait_frame_start();
        p0 = pulses;
        t0 = cyc;
        keys = 16'h0020;
        expect_press(4'h5);
        wait_frames(10);
        total++;
        if (pulses - p0 != 1)
            $display("FAIL k5_count: got %0d want 1", pulses - p0);
        else pass_cnt++;
        total++;
        if (last_pulse - t0 < 4 * FR - 2 ||
            last_pulse - t0 > 5 * FR + 4)
            $display("FAIL k5_latency: got %0d want %0d..%0d",
                     last_pulse - t0, 4 * FR - 2, 5 * FR + 4);
        else pass_cnt++;
        total++;
        if (obs_q.size() == 0) begin
            $display("FAIL k5_sb: got none want %h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL k5_sb: got %h want %h", got, want);
            else pass_cnt++;
        end
        total++;
        if (key_down !== 1'b1)
            $display("FAIL k5_down: got %b want 1", key_down);
        else pass_cnt++;
        keys = 16'h0;
        n = 0;
        while (key_down === 1'b1 && n < 5 * FR) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (key_down !== 1'b0)
            $display("FAIL k5_release: got %b want 0", key_down);
        else pass_cnt++;
        wait_frames(2);
        total++;
        if (pulses - p0 != 1)
            $display("FAIL k5_norepeat: got %0d want 1", pulses - p0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [11:0] got;
        logic [11:0] want;
        p0 = pulses;
        keys = 16'h0008;
        expect_press(4'hA);
        wait_frames(7);
        keys = 16'h0;
        wait_frames(6);
        keys = 16'h2000;
        expect_press(4'hF);
        wait_frames(7);
        keys = 16'h0;
        wait_frames(6);
        total++;
        if (pulses - p0 != 2)
            $display("FAIL b2b_count: got %0d want 2", pulses - p0);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs_q.size() == 0) begin
                $display("FAIL b2b_sb%0d: got none want %h",
                         i, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                got = obs_q.pop_front();
                want = exp_q.pop_front();
                if (got !== want)
                    $display("FAIL b2b_sb%0d: got %h want %h",
                             i, got, want);
                else pass_cnt++;
            end
        end
        total++;
        if (hex_val !== 8'hAF || key_code !== 4'hF)
            $display("FAIL b2b_final: got %h/%h want AF/F",
                     hex_val, key_code);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        int p0;
        int t0;
        logic [11:0] got;
        logic [11:0] want;
        wait_frame_start();
        p0 = pulses;
        for (int i = 0; i < 3 * FR; i++) begin
            keys = (((i / 20) % 2) == 0) ? 16'h0100 : 16'h0;
            @(negedge clk);
        end
        total++;
        if (pulses != p0)
            $display("FAIL bnc_early: got %0d pulses want 0",
                     pulses - p0);
        else pass_cnt++;
        t0 = cyc;
        keys = 16'h0100;
        expect_press(4'h7);
        wait_frames(7);
        total++;
        if (pulses - p0 != 1)
            $display("FAIL bnc_count: got %0d want 1", pulses - p0);
        else pass_cnt++;
        total++;
        if (last_pulse - t0 < 4 * FR - 2)
            $display("FAIL bnc_latency: got %0d want >= %0d",
                     last_pulse - t0, 4 * FR - 2);
        else pass_cnt++;
        total++;
        if (obs_q.size() == 0) begin
            $display("FAIL bnc_sb: got none want %h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL bnc_sb: got %h want %h", got, want);
            else pass_cnt++;
        end
        keys = 16'h0;
        wait_frames(6);
    endtask

    task automatic test_multi();
        int p0;
        logic [11:0] got;
        logic [11:0] want;
        p0 = pulses;
        keys = 16'h0003;
        wait_frames(7);
        total++;
        if (pulses != p0 || key_down !== 1'b0)
            $display("FAIL multi_none: got %0d pulses d=%b want 0 0",
                     pulses - p0, key_down);
        else pass_cnt++;
        keys = 16'h0001;
        expect_press(4'h1);
        wait_frames(7);
        total++;
        if (pulses - p0 != 1)
            $display("FAIL multi_count: got %0d want 1", pulses - p0);
        else pass_cnt++;
        total++;
        if (obs_q.size() == 0) begin
            $display("FAIL multi_sb: got none want %h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL multi_sb: got %h want %h", got, want);
            else pass_cnt++;
        end
        keys = 16'h0;
        wait_frames(6);
    endtask

    task automatic test_en_rst();
        int p0;
        logic [11:0] got;
        logic [11:0] want;
        p0 = pulses;
        keys = 16'h0004;
        expect_press(4'h3);
        wait_frames(7);
        total++;
        if (obs_q.size() == 0) begin
            $display("FAIL en_sb0: got none want %h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL en_sb0: got %h want %h", got, want);
            else pass_cnt++;
        end
        en = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (col_n !== 4'hF || key_down !== 1'b0 ||
            key_valid !== 1'b0)
            $display("FAIL en_off: got col=%h d=%b v=%b want F 0 0",
                     col_n, key_down, key_valid);
        else pass_cnt++;
        total++;
        if (hex_val !== exp_hex || key_code !== 4'h3)
            $display("FAIL en_hold: got %h/%h want %h/3",
                     hex_val, key_code, exp_hex);
        else pass_cnt++;
        en = 1'b1;
        expect_press(4'h3);
        wait_frames(7);
        total++;
        if (pulses - p0 != 2)
            $display("FAIL en_count: got %0d want 2", pulses - p0);
        else pass_cnt++;
        total++;
        if (obs_q.size() == 0) begin
            $display("FAIL en_sb1: got none want %h", exp_q[0]);
            void'(exp_q.pop_front());
        end else begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL en_sb1: got %h want %h", got, want);
            else pass_cnt++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (col_n !== 4'hF || hex_val !== 8'h00 ||
            key_code !== 4'h0)
            $display("FAIL arst_val: got %h/%h/%h want F/00/0",
                     col_n, hex_val, key_code);
        else pass_cnt++;
        total++;
        if (key_down !== 1'b0 || key_valid !== 1'b0)
            $display("FAIL arst_flags: got d=%b v=%b want 0 0",
                     key_down, key_valid);
        else pass_cnt++;
        keys = 16'h0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_key5();
        test_back_to_back();
        test_bounce();
        test_multi();
        test_en_rst();
        total++;
        if (obs_q.size() != 0)
            $display("FAIL sb_extra: got %0d extra pulses want 0",
                     obs_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
